kirby_anim_sequencer: RTL and testbench

Animation sequencer feeding the Kirby sprite frame mapper. It accepts action requests from game logic and steps `character_action_frame_idx` on each display frame tick, wrapping looping actions and returning one-shot actions to idle. Its outputs `character_action_idx` and `character_action_frame_idx` drive the frame mapper directly.

---
 rtl/kirby_anim_pkg.sv | 37 +++
 rtl/frame_tick_gen.sv | 44 ++++
 rtl/kirby_anim_sequencer.sv | 95 +++++++++
 tb/tb_kirby_anim_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/kirby_anim_pkg.sv
// kirby_anim_pkg
// Shared definitions for the Kirby animation sequencer: action indices,
// per-action frame counts and loop flags, the sequencer state type, and
// small lookup helpers that guard against out-of-range action indices.
package kirby_anim_pkg;

  localparam int NUM_ACTIONS = 3;

  localparam logic [2:0] ACT_IDLE   = 3'd0;
  localparam logic [2:0] ACT_WALK   = 3'd1;
  localparam logic [2:0] ACT_INHALE = 3'd2;

  // Indexed by action: idle, walk, inhale.
  localparam logic [3:0] FRAME_COUNT [NUM_ACTIONS] = '{4'd2, 4'd10, 4'd10};
  localparam logic       LOOP_FLAG   [NUM_ACTIONS] = '{1'b1, 1'b1, 1'b0};

  typedef enum logic {
    S_LOOP    = 1'b0,
    S_ONESHOT = 1'b1
  } anim_state_t;

  function automatic logic action_valid(input logic [2:0] act);
    return act < 3'(NUM_ACTIONS);
  endfunction

  // Unknown actions report a single frame so the frame index stays at 0.
  function automatic logic [3:0] frame_count_of(input logic [2:0] act);
    if (action_valid(act)) return FRAME_COUNT[act[1:0]];
    return 4'd1;
  endfunction

  function automatic logic is_looping(input logic [2:0] act);
    if (action_valid(act)) return LOOP_FLAG[act[1:0]];
    return 1'b1;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen
// Detects rising edges of the vsync-rate frame clock and divides them by
// TICKS_PER_FRAME, producing a one-clk frame_advance pulse.
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   frame_clk     frame clock, sampled on clk
//   clear         synchronous clear of the hold counter
//   frame_advance one-clk pulse when an animation frame should advance
module frame_tick_gen #(
  parameter int TICKS_PER_FRAME = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  input  logic clear,
  output logic frame_advance
);

  localparam logic [3:0] LAST_HOLD = 4'(TICKS_PER_FRAME - 1);

  logic       frame_clk_q;
  logic       tick;
  logic [3:0] hold_cnt;

  assign tick          = frame_clk & ~frame_clk_q;
  assign frame_advance = tick && (hold_cnt == LAST_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_clk_q <= 1'b0;
      hold_cnt    <= 4'd0;
    end else begin
      frame_clk_q <= frame_clk;
      // A new action starts its first frame with a full hold period.
      if (clear) begin
        hold_cnt <= 4'd0;
      end else if (tick) begin
        hold_cnt <= (hold_cnt == LAST_HOLD) ? 4'd0 : hold_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/kirby_anim_sequencer.sv
// kirby_anim_sequencer
// Steps the Kirby sprite animation: accepts action requests from game
// logic, advances the frame index on prescaled frame_clk edges, wraps
// looping actions and returns one-shot actions to DEFAULT_ACTION.
// Optional feature macro: ANIM_PREEMPT_EN (requests may interrupt or
// restart a playing one-shot; default build ignores them).
// Ports:
//   Clk                        system clock
//   Reset                      asynchronous active-low reset
//   frame_clk                  vsync-rate frame clock
//   action_req                 requested action index
//   action_req_valid           one-cycle request strobe
//   character_action_idx       current action (registered)
//   character_action_frame_idx current frame within action (registered)
//   busy                       high while a one-shot is playing
//   anim_done                  one-cycle pulse on one-shot completion
module kirby_anim_sequencer
  import kirby_anim_pkg::*;
#(
  parameter int         TICKS_PER_FRAME = 4,
  parameter logic [2:0] DEFAULT_ACTION  = 3'd0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [2:0] action_req,
  input  logic       action_req_valid,
  output logic [2:0] character_action_idx,
  output logic [3:0] character_action_frame_idx,
  output logic       busy,
  output logic       anim_done
);

  anim_state_t state;
  logic        frame_advance;
  logic [3:0]  cur_count;
  logic        at_last;
  logic        complete;
  logic        req_ok;
  logic        accept;

  frame_tick_gen #(
    .TICKS_PER_FRAME(TICKS_PER_FRAME)
  ) u_tick (
    .clk          (Clk),
    .rst_n        (Reset),
    .frame_clk    (frame_clk),
    .clear        (accept),
    .frame_advance(frame_advance)
  );

  assign cur_count = frame_count_of(character_action_idx);
  assign at_last   = (character_action_frame_idx == cur_count - 4'd1);
  assign complete  = (state == S_ONESHOT) && frame_advance && at_last;

`ifdef ANIM_PREEMPT_EN
  // During a one-shot even the same action is accepted, restarting it.
  assign req_ok = action_req_valid && action_valid(action_req) &&
                  ((action_req != character_action_idx) || (state == S_ONESHOT));
`else
  assign req_ok = action_req_valid && action_valid(action_req) &&
                  (state == S_LOOP) && (action_req != character_action_idx);
`endif

  // Completion takes priority over a coincident request.
  assign accept = req_ok && !complete;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state                      <= S_LOOP;
      character_action_idx       <= DEFAULT_ACTION;
      character_action_frame_idx <= 4'd0;
      busy                       <= 1'b0;
      anim_done                  <= 1'b0;
    end else begin
      anim_done <= 1'b0;
      if (accept) begin
        // A coincident frame advance is deliberately discarded here.
        character_action_idx       <= action_req;
        character_action_frame_idx <= 4'd0;
        state                      <= is_looping(action_req) ? S_LOOP : S_ONESHOT;
        busy                       <= !is_looping(action_req);
      end else if (complete) begin
        character_action_idx       <= DEFAULT_ACTION;
        character_action_frame_idx <= 4'd0;
        state                      <= S_LOOP;
        busy                       <= 1'b0;
        anim_done                  <= 1'b1;
      end else if (frame_advance) begin
        character_action_frame_idx <= at_last ? 4'd0 : character_action_frame_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_kirby_anim_sequencer.sv
// tb_kirby_anim_sequencer
// Directed bench for kirby_anim_sequencer with TICKS_PER_FRAME=2, so every
// second frame_clk rising edge advances the animation by one frame.
// Adapts the interrupt scenario to ANIM_PREEMPT_EN when it is defined.
module tb_kirby_anim_sequencer;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [2:0] action_req;
  logic       action_req_valid;
  logic [2:0] character_action_idx;
  logic [3:0] character_action_frame_idx;
  logic       busy;
  logic       anim_done;

  int check_count = 0;
  int error_count = 0;
  int done_count  = 0;
  int done_base   = 0;

  kirby_anim_sequencer #(
    .TICKS_PER_FRAME(2),
    .DEFAULT_ACTION (3'd0)
  ) dut (
    .Clk                       (Clk),
    .Reset                     (Reset),
    .frame_clk                 (frame_clk),
    .action_req                (action_req),
    .action_req_valid          (action_req_valid),
    .character_action_idx      (character_action_idx),
    .character_action_frame_idx(character_action_frame_idx),
    .busy                      (busy),
    .anim_done                 (anim_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // anim_done is a full-cycle pulse, so the falling edge sees each one once.
  always @(negedge Clk) begin
    if (anim_done === 1'b1) done_count++;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic frameEdges(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      step();
      frame_clk = 1'b0;
      step();
    end
  endtask

  task automatic applyStimulus(input logic [2:0] req);
    action_req       = req;
    action_req_valid = 1'b1;
    step();
    action_req_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      error_count++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    Reset            = 1'b0;
    frame_clk        = 1'b0;
    action_req       = 3'd0;
    action_req_valid = 1'b0;
    step();
    step();
    checkOutput("reset_action", character_action_idx, 0);
    checkOutput("reset_frame", character_action_frame_idx, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", anim_done, 0);
    Reset = 1'b1;
    step();

    $display("[TB] idle loop");
    for (int k = 0; k < 4; k++) begin
      frameEdges(2);
      checkOutput("idle_frame", character_action_frame_idx, (k + 1) % 2);
    end
    checkOutput("idle_action", character_action_idx, 0);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] walk loop");
    applyStimulus(3'd1);
    checkOutput("walk_action", character_action_idx, 1);
    checkOutput("walk_frame0", character_action_frame_idx, 0);
    frameEdges(18);
    checkOutput("walk_frame9", character_action_frame_idx, 9);
    frameEdges(2);
    checkOutput("walk_wrap", character_action_frame_idx, 0);
    frameEdges(2);
    checkOutput("walk_frame1", character_action_frame_idx, 1);

    $display("[TB] inhale one-shot");
    applyStimulus(3'd2);
    checkOutput("inhale_action", character_action_idx, 2);
    checkOutput("inhale_busy", busy, 1);
    checkOutput("inhale_frame0", character_action_frame_idx, 0);
    done_base = done_count;
    frameEdges(18);
    checkOutput("inhale_frame9", character_action_frame_idx, 9);
    checkOutput("inhale_busy9", busy, 1);
    checkOutput("inhale_no_early_done", done_count, done_base);
    frameEdges(2);
    checkOutput("inhale_end_action", character_action_idx, 0);
    checkOutput("inhale_end_frame", character_action_frame_idx, 0);
    checkOutput("inhale_end_busy", busy, 0);
    checkOutput("inhale_done_once", done_count, done_base + 1);

    $display("[TB] request during inhale");
    applyStimulus(3'd2);
    frameEdges(4);
    checkOutput("int_frame2", character_action_frame_idx, 2);
    done_base = done_count;
    applyStimulus(3'd1);
`ifdef ANIM_PREEMPT_EN
    checkOutput("preempt_action", character_action_idx, 1);
    checkOutput("preempt_frame", character_action_frame_idx, 0);
    checkOutput("preempt_busy", busy, 0);
    frameEdges(4);
    checkOutput("preempt_walk_frame", character_action_frame_idx, 2);
    checkOutput("preempt_no_done", done_count, done_base);
    applyStimulus(3'd0);
    checkOutput("preempt_back_idle", character_action_idx, 0);
`else
    checkOutput("ignore_action", character_action_idx, 2);
    checkOutput("ignore_frame", character_action_frame_idx, 2);
    checkOutput("ignore_busy", busy, 1);
    frameEdges(16);
    checkOutput("ignore_end_action", character_action_idx, 0);
    checkOutput("ignore_end_busy", busy, 0);
    checkOutput("ignore_done_once", done_count, done_base + 1);
`endif
    checkOutput("int_end_frame", character_action_frame_idx, 0);

    $display("[TB] ignored requests");
    frameEdges(2);
    checkOutput("idle_frame1", character_action_frame_idx, 1);
    applyStimulus(3'd0);
    checkOutput("same_req_frame", character_action_frame_idx, 1);
    checkOutput("same_req_action", character_action_idx, 0);
    applyStimulus(3'd5);
    checkOutput("bad_req_action", character_action_idx, 0);
    checkOutput("bad_req_frame", character_action_frame_idx, 1);
    checkOutput("bad_req_busy", busy, 0);

    $display("[TB] request coincident with advance");
    frameEdges(1);
    frame_clk        = 1'b1;
    action_req       = 3'd1;
    action_req_valid = 1'b1;
    step();
    action_req_valid = 1'b0;
    checkOutput("coinc_action", character_action_idx, 1);
    checkOutput("coinc_frame", character_action_frame_idx, 0);
    frame_clk = 1'b0;
    step();
    frameEdges(2);
    checkOutput("coinc_next_frame", character_action_frame_idx, 1);

    $display("[TB] completion coincident with request");
    applyStimulus(3'd2);
    frameEdges(19);
    checkOutput("cmp_frame9", character_action_frame_idx, 9);
    done_base        = done_count;
    frame_clk        = 1'b1;
    action_req       = 3'd1;
    action_req_valid = 1'b1;
    step();
    action_req_valid = 1'b0;
    checkOutput("cmp_action", character_action_idx, 0);
    checkOutput("cmp_done_pulse", anim_done, 1);
    checkOutput("cmp_busy", busy, 0);
    frame_clk = 1'b0;
    step();
    checkOutput("cmp_done_low", anim_done, 0);
    checkOutput("cmp_done_once", done_count, done_base + 1);

    $display("[TB] reset mid one-shot");
    applyStimulus(3'd2);
    frameEdges(12);
    checkOutput("rst_pre_frame", character_action_frame_idx, 6);
    done_base = done_count;
    Reset = 1'b0;
    #2;
    checkOutput("rst_action", character_action_idx, 0);
    checkOutput("rst_frame", character_action_frame_idx, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", anim_done, 0);
    step();
    step();
    checkOutput("rst_no_done", done_count, done_base);
    Reset = 1'b1;
    step();
    frameEdges(2);
    checkOutput("post_rst_frame", character_action_frame_idx, 1);
    checkOutput("post_rst_action", character_action_idx, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
